// File: rtl/input_buffer_ctrl_if.sv
// Bus for the input buffer controller: the loader's word handshake, frame control,
// the buffer port drives, the read-data qualifiers and a debug view of the FSM state.
interface input_buffer_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = ADDR_W + 1
);
  // Loader handshake: a word transfers on every cycle where in_valid and in_ready
  // are both high. in_valid may rise whenever it likes. in_ready never depends on
  // in_valid, so a waiting loader cannot deadlock against the controller.
  logic              in_valid;
  logic              in_ready;
  logic              frame_start;
  logic [LEN_W-1:0]  frame_len;
  logic              frame_busy;
  logic              frame_done;
  logic              err_len;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic              out_valid;
  logic              out_last;
  logic [LEN_W-1:0]  level;
  logic [1:0]        state_dbg;

  modport master (
    output in_valid, frame_start, frame_len,
    input  in_ready, frame_busy, frame_done, err_len,
    input  buf_wr_en, buf_wr_addr, buf_rd_en, buf_rd_addr,
    input  out_valid, out_last, level, state_dbg
  );

  modport slave (
    input  in_valid, frame_start, frame_len,
    output in_ready, frame_busy, frame_done, err_len,
    output buf_wr_en, buf_wr_addr, buf_rd_en, buf_rd_addr,
    output out_valid, out_last, level, state_dbg
  );
endinterface

// File: rtl/input_buffer_ctrl.sv
// Controller for a circular input buffer: accepts loader words at any time and reads
// out requested frames, driving the buffer's write and read ports.
module input_buffer_ctrl #(
  parameter int CTRL_ADDR_WIDTH = 4,
  parameter int CTRL_LEN_WIDTH  = CTRL_ADDR_WIDTH + 1
) (
  input logic                clk,
  input logic                rst,
  input_buffer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [CTRL_LEN_WIDTH-1:0] DEPTH = CTRL_LEN_WIDTH'(2 ** CTRL_ADDR_WIDTH);
  localparam logic [CTRL_LEN_WIDTH-1:0] ONE   = CTRL_LEN_WIDTH'(1);

  state_e                     state_q, state_d;
  logic [CTRL_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CTRL_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CTRL_LEN_WIDTH-1:0]  level_q, level_d;
  logic [CTRL_LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                       err_len_q, err_len_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;

  logic in_ready;
  logic wr_en;
  logic rd_en;
  logic len_ok;
  logic last_issue;

  // Both enables come from the registered level, so a write and a read in the same
  // cycle always target different slots: reads only reach slots already written.
  always_comb begin
    in_ready   = (level_q < DEPTH) && !rst;
    wr_en      = bus.in_valid && in_ready;
    rd_en      = (state_q == ST_READ) && (level_q != '0);
    last_issue = rd_en && (remaining_q == ONE);
    len_ok     = (bus.frame_len != '0) && (bus.frame_len <= DEPTH);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = rd_en;
    out_last_d  = last_issue;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    err_len_d   = err_len_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start) begin
          if (len_ok) begin
            remaining_d = bus.frame_len;
            state_d     = ST_READ;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (rd_en) begin
          remaining_d = remaining_q - ONE;
        end
        if (last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      remaining_q <= '0;
      err_len_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      remaining_q <= remaining_d;
      err_len_q   <= err_len_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // frame_done is decoded from DRAIN, which is exactly the cycle the final word's
  // registered out_valid/out_last appear.
  assign bus.in_ready    = in_ready;
  assign bus.buf_wr_en   = wr_en;
  assign bus.buf_wr_addr = wr_ptr_q;
  assign bus.buf_rd_en   = rd_en;
  assign bus.buf_rd_addr = rd_ptr_q;
  assign bus.frame_busy  = (state_q != ST_IDLE);
  assign bus.frame_done  = (state_q == ST_DRAIN);
  assign bus.err_len     = err_len_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.level       = level_q;
  assign bus.state_dbg   = state_q;

endmodule
